// File: rtl/ram_boot_loader_if.sv
// Boot loader signal bundle: start/config, byte stream, RAM priority write port, status.
interface ram_boot_loader_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  // load request and image description
  logic              start;
  logic              boot_skip;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length_words;

  // byte stream from the UART/debug receiver
  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_ready;

  // RAM priority write port
  logic              write;
  logic [ADDR_W-1:0] wraddrin;
  logic [WORD_W-1:0] wrdatain;

  // CPU hold and status
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  // loader side
  modport slave (
    input  start, boot_skip, base_addr, length_words, rx_valid, rx_data,
    output rx_ready, write, wraddrin, wrdatain, cpu_hold, busy, done, err
  );

  // requester / stream source / observer side
  modport master (
    output start, boot_skip, base_addr, length_words, rx_valid, rx_data,
    input  rx_ready, write, wraddrin, wrdatain, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/ram_boot_loader.sv
// Fills code/data RAM from a little-endian byte stream, verifies an additive
// checksum and releases the CPU hold only when the image is good.
module ram_boot_loader #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             hclk,
  input  logic             hresetn,
  ram_boot_loader_if.slave bus
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PART_W = 24;
  localparam int unsigned TMO_W  = 32;
  // last idle-count value before the timeout edge; unused when TIMEOUT is 0
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  state_e state_q, state_d;

  // image bookkeeping
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [PART_W-1:0] part_q, part_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  // registered outputs
  logic              rx_ready_q, rx_ready_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] wraddr_q, wraddr_d;
  logic [WORD_W-1:0] wrdata_q, wrdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // per-cycle decode
  logic              accept_c;
  logic              word_end_c;
  logic [WORD_W-1:0] word_c;
  logic [ADDR_W-1:0] idx_inc_c;
  logic              start_ok_c;
  logic              tmo_hit_c;
  logic              in_xfer_c;
  state_e            start_tgt_c;

  // byte handshake, word assembly and restart decode
  always_comb begin
    accept_c    = bus.rx_valid & rx_ready_q;
    word_end_c  = (bcnt_q == 2'd3);
    word_c      = {bus.rx_data, part_q};
    idx_inc_c   = idx_q + ADDR_W'(1);
    in_xfer_c   = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    start_ok_c  = bus.start &&
                  ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    start_tgt_c = (bus.length_words == '0) ? ST_CHECK : ST_LOAD;
    tmo_hit_c   = (TIMEOUT != 0) && in_xfer_c && !accept_c && (tmo_q == TMO_LAST);
  end

  // state register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = start_tgt_c;
        end else if (bus.boot_skip) begin
          state_d = ST_DONE;
        end
      end
      ST_LOAD: begin
        if (accept_c && word_end_c && (idx_inc_c == len_q)) begin
          state_d = ST_CHECK;
        end else if (tmo_hit_c) begin
          state_d = ST_ERR;
        end
      end
      ST_CHECK: begin
        if (accept_c && word_end_c) begin
          state_d = (word_c == sum_q) ? ST_DONE : ST_ERR;
        end else if (tmo_hit_c) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE, ST_ERR: begin
        if (bus.start) begin
          state_d = start_tgt_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath and output next values
  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    part_d     = part_q;
    sum_d      = sum_q;
    tmo_d      = tmo_q;
    write_d    = 1'b0;
    wraddr_d   = wraddr_q;
    wrdata_d   = wrdata_q;

    if (start_ok_c) begin
      // fresh image: latch geometry, clear all accumulation
      base_d = bus.base_addr;
      len_d  = bus.length_words;
      idx_d  = '0;
      bcnt_d = '0;
      part_d = '0;
      sum_d  = '0;
      tmo_d  = '0;
    end else if (in_xfer_c) begin
      if (accept_c) begin
        tmo_d  = '0;
        bcnt_d = bcnt_q + 2'd1;
        if (word_end_c) begin
          part_d = '0;
          if (state_q == ST_LOAD) begin
            write_d  = 1'b1;
            wraddr_d = base_q + idx_q;
            wrdata_d = word_c;
            sum_d    = sum_q + word_c;
            idx_d    = idx_inc_c;
          end
        end else begin
          unique case (bcnt_q)
            2'd0:    part_d[7:0]   = bus.rx_data;
            2'd1:    part_d[15:8]  = bus.rx_data;
            default: part_d[23:16] = bus.rx_data;
          endcase
        end
      end else if (TIMEOUT != 0) begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    // status follows the state being entered so it is valid the cycle after the edge
    rx_ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
    cpu_hold_d = (state_d != ST_DONE);
  end

  // datapath and output registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      part_q     <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      rx_ready_q <= 1'b0;
      write_q    <= 1'b0;
      wraddr_q   <= '0;
      wrdata_q   <= '0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      part_q     <= part_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      rx_ready_q <= rx_ready_d;
      write_q    <= write_d;
      wraddr_q   <= wraddr_d;
      wrdata_q   <= wrdata_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.write    = write_q;
  assign bus.wraddrin = wraddr_q;
  assign bus.wrdatain = wrdata_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ram_boot_loader.sv
// Self-checking bench for ram_boot_loader: directed scenarios plus random images
// checked against a word-level model of the image (addresses, data, checksum).
module tb_ram_boot_loader;

  localparam int unsigned TMO = 100;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  ram_boot_loader_if bus();

  ram_boot_loader #(.TIMEOUT(TMO)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  always @(posedge hclk) cyc <= cyc + 1;

  // observed RAM writes
  logic [15:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int unsigned wr_cyc_q[$];

  always @(negedge hclk) begin
    if (hresetn && bus.write) begin
      wr_addr_q.push_back(bus.wraddrin);
      wr_data_q.push_back(bus.wrdatain);
      wr_cyc_q.push_back(cyc);
    end
  end

  // image under test and the edges at which each word completed
  logic [31:0] img[$];
  int unsigned acc_cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit r;
    int n;
    n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    do begin
      @(negedge hclk);
      r = bus.rx_ready;
      @(posedge hclk);
      n++;
    end while (!r && n < 50);
    #1;
    bus.rx_valid = 1'b0;
    if (!r) chk("rx_accept", 32'(0), 32'(1));
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int k = 0; k < 4; k++) begin
      if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic pulse_start(input logic [15:0] base, input logic [15:0] len);
    bus.base_addr    = base;
    bus.length_words = len;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
  endtask

  function automatic logic [31:0] img_sum();
    logic [31:0] s;
    s = '0;
    foreach (img[i]) s = s + img[i];
    return s;
  endfunction

  // load img at base, send chk_val as checksum, compare against the model
  task automatic run_image(input logic [15:0] base, input logic [31:0] chk_val,
                           input bit exp_ok, input int gap_max, input bit mid_start,
                           input string tag);
    int len;
    int n;
    len = img.size();
    clear_writes();
    acc_cyc_q.delete();
    pulse_start(base, 16'(len));
    chk({tag, "_start"}, 32'({bus.busy, bus.rx_ready, bus.cpu_hold, bus.done, bus.err}),
        32'(5'b11100));
    for (int i = 0; i < len; i++) begin
      send_word(img[i], gap_max);
      acc_cyc_q.push_back(cyc);
      if (mid_start && i == 0) begin
        pulse_start(16'($urandom), 16'd7);
        chk({tag, "_midstart"}, 32'({bus.busy, bus.rx_ready}), 32'(2'b11));
      end
    end
    send_word(chk_val, gap_max);
    chk({tag, "_end"}, 32'({bus.done, bus.err, bus.cpu_hold, bus.busy}),
        32'({exp_ok, !exp_ok, !exp_ok, 1'b0}));
    // bytes offered after completion must be refused
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    idle(3);
    chk({tag, "_norx"}, 32'(bus.rx_ready), 32'(0));
    bus.rx_valid = 1'b0;
    idle(1);
    chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(len));
    n = (wr_addr_q.size() < len) ? wr_addr_q.size() : len;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(16'(32'(base) + i)));
      chk({tag, "_data"}, wr_data_q[i], img[i]);
      chk({tag, "_wcyc"}, wr_cyc_q[i], acc_cyc_q[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] sum;
    logic [31:0] cv;
    bit          good;
    int          n;

    bus.start        = 1'b0;
    bus.boot_skip    = 1'b0;
    bus.base_addr    = '0;
    bus.length_words = '0;
    bus.rx_valid     = 1'b0;
    bus.rx_data      = '0;
    hresetn          = 1'b0;
    idle(3);
    #2 hresetn = 1'b1;
    idle(20);
    chk("reset", 32'({bus.cpu_hold, bus.rx_ready, bus.write, bus.busy, bus.done, bus.err}),
        32'(6'b100000));

    // directed image from the reference vectors
    img = '{32'h1234_5678, 32'hDEAD_BEEF};
    run_image(16'h0100, 32'hF0E2_1567, 1'b1, 0, 1'b0, "dir_ok");
    chk("dir_sum_model", img_sum(), 32'hF0E2_1567);

    // wrong checksum, then reload the correct one from ERR
    run_image(16'h0100, 32'h0000_0000, 1'b0, 0, 1'b0, "dir_bad");
    run_image(16'h0100, 32'hF0E2_1567, 1'b1, 1, 1'b0, "dir_reload");

    // address wrap and an ignored start mid-load
    img = '{$urandom, $urandom};
    run_image(16'hFFFF, img_sum(), 1'b1, 2, 1'b1, "wrap");

    // stall after two bytes: abort exactly TMO edges after the last accepted byte
    clear_writes();
    pulse_start(16'h0200, 16'd3);
    send_byte(8'h11);
    send_byte(8'h22);
    n = 0;
    while (!bus.err && n < 3 * TMO) begin
      tick();
      n++;
    end
    chk("tmo_edges", 32'(n), 32'(TMO));
    chk("tmo_state", 32'({bus.err, bus.busy, bus.cpu_hold, bus.rx_ready}), 32'(4'b1010));
    chk("tmo_nwr", 32'(wr_addr_q.size()), 32'(0));

    // empty image: zero checksum only
    img.delete();
    run_image(16'h0400, 32'h0, 1'b1, 0, 1'b0, "len0");

    // asynchronous reset while a write strobe is high
    img.delete();
    pulse_start(16'h0300, 16'd4);
    send_word(32'hCAFE_F00D, 0);
    chk("pre_rst_write", 32'({bus.write, bus.wraddrin}), 32'({1'b1, 16'h0300}));
    #2 hresetn = 1'b0;
    #1;
    chk("async_rst", 32'({bus.cpu_hold, bus.write, bus.rx_ready, bus.busy, bus.done, bus.err}),
        32'(6'b100000));
    chk("async_rst_bus", 32'({bus.wraddrin, bus.wrdatain[15:0]}), 32'(0));
    idle(2);
    hresetn = 1'b1;
    idle(2);

    // boot skip from IDLE
    bus.boot_skip = 1'b1;
    tick();
    bus.boot_skip = 1'b0;
    chk("boot_skip", 32'({bus.done, bus.cpu_hold, bus.busy, bus.err}), 32'(4'b1000));

    // random images against the word-level model
    for (int it = 0; it < 8; it++) begin
      img.delete();
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++) img.push_back($urandom);
      sum  = img_sum();
      good = ($urandom_range(0, 2) != 0);
      cv   = good ? sum : (sum ^ (32'h1 << $urandom_range(0, 31)));
      run_image(16'($urandom), cv, (cv == sum), 3, 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
